// File: rtl/pipe_lsu.sv
// pipe_lsu: MEM-stage load/store unit driving a word-wide data memory port.
// It turns byte/halfword/word requests into word-aligned accesses. Sub-word
// stores are merged into the current word, and loads are sign- or zero-extended.
// Optional feature macro: MISALIGN_SPLIT_EN. When it is defined, an access that
// crosses a word boundary is split into two word accesses with a one-cycle stall.
// When it is undefined, such an access is rejected with err.
module pipe_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  logic [1:0]  off;
  logic [2:0]  nbytes;
  logic [3:0]  size_mask;
  logic        reserved;
  logic        crossing;
  logic [31:0] base_addr;
  logic [63:0] wide_data;   // store data placed at its byte lanes across two words
  logic [7:0]  wide_mask;   // byte enables across the same two-word window
  logic        second_sel;  // currently serving the upper word of a split
  logic [31:0] lane_data;
  logic [3:0]  lane_mask;
  logic [31:0] merged;
  logic [31:0] aligned_raw;
  logic [31:0] load_raw;
  logic [31:0] load_ext;
  logic        active;

`ifdef MISALIGN_SPLIT_EN
  localparam logic SPLIT = 1'b1;

  typedef enum logic {IDLE, SECOND} state_t;
  state_t      state;
  logic [23:0] hold;        // upper bytes of the first word of a split load
  logic [2:0]  hi_shift;
  logic [31:0] split_raw;

  assign second_sel = (state == SECOND);
`else
  localparam logic SPLIT = 1'b0;

  // No registered state in this build; the clock and reset are kept on the port list.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;
  assign second_sel     = 1'b0;
`endif

  // Decode access size into a byte count and a right-aligned byte mask
  always_comb begin
    nbytes    = 3'd0;
    size_mask = 4'b0000;
    case (req_size)
      2'b00:   begin nbytes = 3'd1; size_mask = 4'b0001; end
      2'b01:   begin nbytes = 3'd2; size_mask = 4'b0011; end
      2'b10:   begin nbytes = 3'd4; size_mask = 4'b1111; end
      default: begin nbytes = 3'd0; size_mask = 4'b0000; end
    endcase
  end

  assign off       = req_addr[1:0];
  assign reserved  = (req_size == 2'b11);
  assign crossing  = (({1'b0, off} + nbytes) > 3'd4);
  assign base_addr = {req_addr[31:2], 2'b00};
  assign wide_data = {32'd0, req_wdata} << {off, 3'b000};
  assign wide_mask = {4'd0, size_mask} << off;

  // The lower word is served in the first (or only) cycle, and the upper word in SECOND
  assign lane_data = second_sel ? wide_data[63:32] : wide_data[31:0];
  assign lane_mask = second_sel ? wide_mask[7:4]   : wide_mask[3:0];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign merged[8*gi +: 8] = lane_mask[gi] ? lane_data[8*gi +: 8] : mem_rdata[8*gi +: 8];
    end
  endgenerate

  // Load bytes are shifted down so the addressed byte lands in bits [7:0]
  assign aligned_raw = mem_rdata >> {off, 3'b000};

`ifdef MISALIGN_SPLIT_EN
  // The held bytes fill the low (4-off) bytes, and word B supplies the rest above them
  assign hi_shift  = 3'd4 - {1'b0, off};
  assign split_raw = {8'd0, hold} | (mem_rdata << {hi_shift, 3'b000});
  assign load_raw  = second_sel ? split_raw : aligned_raw;
`else
  assign load_raw  = aligned_raw;
`endif

  // Sign- or zero-extend the assembled load value to 32 bits
  always_comb begin
    case (req_size)
      2'b00:   load_ext = {{24{load_raw[7]  & ~req_unsigned}}, load_raw[7:0]};
      2'b01:   load_ext = {{16{load_raw[15] & ~req_unsigned}}, load_raw[15:0]};
      default: load_ext = load_raw;
    endcase
  end

  // Accept or reject the request and drive the memory port and result outputs
  always_comb begin
    err    = 1'b0;
    active = 1'b0;
    if (second_sel) begin
      // The split always finishes, even if req_valid drops in the meantime
      active = 1'b1;
    end else if (req_valid) begin
      if (reserved || (crossing && !SPLIT)) err = 1'b1;
      else                                  active = 1'b1;
    end
    stall       = active && !second_sel && crossing;
    mem_we      = active && req_we;
    mem_addr    = active ? (second_sel ? base_addr + 32'd4 : base_addr) : 32'd0;
    mem_wdata   = mem_we ? merged : 32'd0;
    rdata_valid = active && !req_we && !stall;
    rdata       = rdata_valid ? load_ext : 32'd0;
  end

`ifdef MISALIGN_SPLIT_EN
  // Move between the two halves of a split and capture the first word's load bytes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      hold  <= 24'd0;
    end else begin
      case (state)
        IDLE: begin
          if (stall) begin
            state <= SECOND;
            hold  <= aligned_raw[23:0];
          end
        end
        SECOND: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_pipe_lsu.sv
// tb_pipe_lsu: scoreboard bench for pipe_lsu. The stimulus pushes hand-computed
// expected responses, and a monitor pops one expected response for every cycle
// in which the DUT shows activity. The bench follows MISALIGN_SPLIT_EN for
// crossing accesses.
module tb_pipe_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        tb_wr = 1'b0;
  logic [31:0] tb_wa = 32'd0;
  logic [31:0] tb_wd = 32'd0;

  logic [31:0] mem [16];

  int checks = 0;
  int errors = 0;

`ifdef MISALIGN_SPLIT_EN
  localparam int XC = 2;
`else
  localparam int XC = 1;
`endif

  pipe_lsu dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
    .err(err), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Small word memory, combinational read, write at the rising edge
  assign mem_rdata = mem[mem_addr[5:2]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[5:2]] <= mem_wdata;
    if (tb_wr)  mem[tb_wa[5:2]]    <= tb_wd;
  end

  typedef struct {
    int          id;
    logic        stall;
    logic        err;
    logic        rv;
    logic [31:0] rdata;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  logic ok;

  function automatic void expect_out(input int id, input logic st, input logic er, input logic rv,
                                     input logic [31:0] rd, input logic we,
                                     input logic [31:0] ad, input logic [31:0] wd);
    exp_t x;
    x.id = id; x.stall = st; x.err = er; x.rv = rv; x.rdata = rd;
    x.we = we; x.addr = ad; x.wdata = wd;
    exp_q.push_back(x);
  endfunction

  function automatic void expect_load(input int id, input logic [31:0] ad, input logic [31:0] rd);
    expect_out(id, 1'b0, 1'b0, 1'b1, rd, 1'b0, ad, 32'd0);
  endfunction

  function automatic void expect_store(input int id, input logic [31:0] ad, input logic [31:0] wd);
    expect_out(id, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, ad, wd);
  endfunction

  function automatic void expect_err(input int id);
    expect_out(id, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
  endfunction

  function automatic void expect_split_load(input int id, input logic [31:0] a0,
                                            input logic [31:0] a1, input logic [31:0] rd);
`ifdef MISALIGN_SPLIT_EN
    expect_out(id, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, a0, 32'd0);
    expect_load(id + 1, a1, rd);
`else
    expect_err(id);
`endif
  endfunction

  function automatic void expect_split_store(input int id, input logic [31:0] a0, input logic [31:0] w0,
                                             input logic [31:0] a1, input logic [31:0] w1);
`ifdef MISALIGN_SPLIT_EN
    expect_out(id, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, a0, w0);
    expect_store(id + 1, a1, w1);
`else
    expect_err(id);
`endif
  endfunction

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd, input int cycles);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    repeat (cycles) begin @(posedge clk); #1; end
  endtask

  task automatic idle(input int cycles);
    req_valid = 1'b0;
    repeat (cycles) begin @(posedge clk); #1; end
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] data);
    req_valid = 1'b0; tb_wa = addr; tb_wd = data; tb_wr = 1'b1;
    @(posedge clk); #1;
    tb_wr = 1'b0;
  endtask

  // Monitor: any visible DUT activity must match the next expected response
  always @(negedge clk) begin
    if (!rst && (stall || err || rdata_valid || mem_we)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: stall=%0b err=%0b rdata_valid=%0b rdata=%h mem_we=%0b mem_addr=%h, required no activity",
                 stall, err, rdata_valid, rdata, mem_we, mem_addr);
      end else begin
        e = exp_q.pop_front();
        ok = (stall == e.stall) && (err == e.err) && (rdata_valid == e.rv) && (mem_we == e.we)
          && (!(e.rv || e.err) || rdata == e.rdata)
          && (!(e.we || e.rv || e.stall) || mem_addr == e.addr)
          && (!e.we || mem_wdata == e.wdata);
        if (ok) begin
          $display("txn %0d: stall=%0b err=%0b rv=%0b rdata=%h we=%0b addr=%h wdata=%h ok",
                   e.id, stall, err, rdata_valid, rdata, mem_we, mem_addr, mem_wdata);
        end else begin
          errors++;
          $display("FAIL txn_%0d: got stall=%0b err=%0b rv=%0b rdata=%h we=%0b addr=%h wdata=%h, required stall=%0b err=%0b rv=%0b rdata=%h we=%0b addr=%h wdata=%h",
                   e.id, stall, err, rdata_valid, rdata, mem_we, mem_addr, mem_wdata,
                   e.stall, e.err, e.rv, e.rdata, e.we, e.addr, e.wdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (stall || err || rdata_valid || mem_we || rdata != 32'd0 || mem_addr != 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: stall=%0b err=%0b rv=%0b we=%0b rdata=%h addr=%h, required all zero",
               stall, err, rdata_valid, mem_we, rdata, mem_addr);
    end else begin
      $display("reset: outputs idle ok");
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Aligned loads
    preload(32'h10, 32'h11223344);
    expect_load(1, 32'h10, 32'h00000011);   issue(1'b0, 2'b00, 1'b0, 32'h13, 32'd0, 1);
    expect_load(2, 32'h10, 32'h00001122);   issue(1'b0, 2'b01, 1'b1, 32'h12, 32'd0, 1);
    expect_load(3, 32'h10, 32'h11223344);   issue(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 1);
    preload(32'h10, 32'h000000F0);
    expect_load(4, 32'h10, 32'hFFFFFFF0);   issue(1'b0, 2'b00, 1'b0, 32'h10, 32'd0, 1);
    expect_load(5, 32'h10, 32'h000000F0);   issue(1'b0, 2'b00, 1'b1, 32'h10, 32'd0, 1);

    // Aligned stores with read-modify-write
    preload(32'h20, 32'h11223344);
    expect_store(6, 32'h20, 32'h1122AB44);  issue(1'b1, 2'b00, 1'b0, 32'h21, 32'h123456AB, 1);
    preload(32'h20, 32'h11223344);
    expect_store(7, 32'h20, 32'hBEEF3344);  issue(1'b1, 2'b01, 1'b0, 32'h22, 32'h9999BEEF, 1);
    expect_load(8, 32'h20, 32'hBEEF3344);   issue(1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 1);
    expect_err(9);                          issue(1'b1, 2'b11, 1'b0, 32'h20, 32'hDEADBEEF, 1);
    expect_load(10, 32'h20, 32'hBEEF3344);  issue(1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 1);
    expect_store(11, 32'h24, 32'hCAFEF00D); issue(1'b1, 2'b10, 1'b0, 32'h24, 32'hCAFEF00D, 1);
    idle(1);

    // Upper-boundary aligned accesses, then word-crossing accesses
    preload(32'h30, 32'h11223344);
    preload(32'h34, 32'h55667788);
    expect_load(12, 32'h30, 32'h00001122);  issue(1'b0, 2'b01, 1'b0, 32'h32, 32'd0, 1);
    expect_load(13, 32'h30, 32'h00000011);  issue(1'b0, 2'b00, 1'b0, 32'h33, 32'd0, 1);
    expect_load(14, 32'h34, 32'hFFFFFF88);  issue(1'b0, 2'b00, 1'b0, 32'h34, 32'd0, 1);
    expect_split_load(15, 32'h30, 32'h34, 32'h77881122);
    issue(1'b0, 2'b10, 1'b0, 32'h32, 32'd0, XC);
    expect_split_store(17, 32'h30, 32'hDD223344, 32'h34, 32'h55AABBCC);
    issue(1'b1, 2'b10, 1'b0, 32'h33, 32'hAABBCCDD, XC);
`ifdef MISALIGN_SPLIT_EN
    expect_load(19, 32'h30, 32'hDD223344);
    expect_load(20, 32'h34, 32'h55AABBCC);
`else
    expect_load(19, 32'h30, 32'h11223344);
    expect_load(20, 32'h34, 32'h55667788);
`endif
    issue(1'b0, 2'b10, 1'b0, 32'h30, 32'd0, 1);
    issue(1'b0, 2'b10, 1'b0, 32'h34, 32'd0, 1);

    // Address wrap on the second word
    preload(32'hFFFFFFFC, 32'h12345678);
    preload(32'h00000000, 32'h9ABCDEF0);
    expect_split_load(21, 32'hFFFFFFFC, 32'h00000000, 32'hFFFFF012);
    issue(1'b0, 2'b01, 1'b0, 32'hFFFFFFFF, 32'd0, XC);
    expect_load(23, 32'hFFFFFFFC, 32'h00001234);
    issue(1'b0, 2'b01, 1'b1, 32'hFFFFFFFE, 32'd0, 1);

    // Reset asserted while in the second half of a split store
    preload(32'h30, 32'h11223344);
    preload(32'h34, 32'h55667788);
`ifdef MISALIGN_SPLIT_EN
    expect_out(24, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'h30, 32'hDD223344);
`else
    expect_err(24);
`endif
    issue(1'b1, 2'b10, 1'b0, 32'h33, 32'hAABBCCDD, 1);
    rst = 1'b1;
    req_valid = 1'b0;
    #1;
    checks++;
    if (stall || mem_we || mem_addr != 32'd0) begin
      errors++;
      $display("FAIL reset_abort: stall=%0b mem_we=%0b mem_addr=%h, required 0 0 00000000",
               stall, mem_we, mem_addr);
    end else begin
      $display("reset during split: outputs idle ok");
    end
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);
    expect_load(25, 32'h34, 32'h55667788);  issue(1'b0, 2'b10, 1'b0, 32'h34, 32'd0, 1);
`ifdef MISALIGN_SPLIT_EN
    expect_load(26, 32'h30, 32'hDD223344);
`else
    expect_load(26, 32'h30, 32'h11223344);
`endif
    issue(1'b0, 2'b10, 1'b0, 32'h30, 32'd0, 1);
    idle(3);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_expected: %0d responses never seen, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
